// File: rtl/ooo_pkg.sv
// Shared out-of-order core constants: register-file geometry and the physical tag type.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ooo_pkg;

  localparam int NUM_PHYS_REGS = 64;
  localparam int NUM_ARCH_REGS = 32;
  localparam int PREG_BITS     = $clog2(NUM_PHYS_REGS);

  typedef logic [PREG_BITS-1:0] preg_t;

endpackage

// File: rtl/lane_prefix_count.sv
// Per-lane exclusive prefix popcount of a lane mask, plus the total set-lane count.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result follows the input mask every cycle.
module lane_prefix_count #(
  parameter  int LANES = 4,
  localparam int CW    = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0]         i_vec,
  output logic [LANES-1:0][CW-1:0] o_prefix,
  output logic [CW-1:0]            o_total
);

  // Running sum: lane i sees how many lanes below it are set.
  always_comb begin
    logic [CW-1:0] acc;
    acc = '0;
    o_prefix = '0;
    for (int i = 0; i < LANES; i++) begin
      o_prefix[i] = acc;
      acc = acc + CW'(i_vec[i]);
    end
    o_total = acc;
  end

endmodule

// File: rtl/phys_free_list.sv
// Physical-register free list: circular tag store with speculative/architectural heads and a release tail.
// Latency: allocation tags and grants are same-cycle combinational; releases become allocatable next cycle.
// Backpressure: all-or-nothing grant when enough tags are free and no flush; excess releases dropped and flagged in err.
module phys_free_list
  import ooo_pkg::*;
#(
  parameter  int NUM_PHYS_REGS = ooo_pkg::NUM_PHYS_REGS,
  parameter  int NUM_ARCH_REGS = ooo_pkg::NUM_ARCH_REGS,
  parameter  int ALLOC_WIDTH   = 4,
  parameter  int FREE_WIDTH    = 4,
  localparam int PREG_W        = $clog2(NUM_PHYS_REGS),
  localparam int FL_DEPTH      = NUM_PHYS_REGS - NUM_ARCH_REGS,
  localparam int CNT_W         = $clog2(FL_DEPTH + 1),
  localparam int ACNT_W        = $clog2(ALLOC_WIDTH + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [ALLOC_WIDTH-1:0]             alloc_req,
  output logic [ALLOC_WIDTH-1:0]             alloc_grant,
  output logic [ALLOC_WIDTH-1:0][PREG_W-1:0] alloc_tag,
  input  logic [FREE_WIDTH-1:0]              free_en,
  input  logic [FREE_WIDTH-1:0][PREG_W-1:0]  free_tag,
  input  logic [ACNT_W-1:0]                  commit_alloc_cnt,
  input  logic                               flush,
  output logic [CNT_W-1:0]                   free_count,
  output logic                               empty,
  output logic                               err
);

  localparam int IDX_W  = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FREE_WIDTH + 1);

  typedef logic [PREG_W-1:0] tag_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef struct packed {
    logic wrap;
    idx_t idx;
  } ptr_t;

  // Index arithmetic wraps at FL_DEPTH, which need not be a power of two.
  function automatic idx_t idx_add(idx_t i, int n);
    int s;
    s = int'(i) + n;
    if (s >= FL_DEPTH) s = s - FL_DEPTH;
    return idx_t'(s);
  endfunction

  function automatic ptr_t ptr_add(ptr_t p, int n);
    ptr_t r;
    int   s;
    s      = int'(p.idx) + n;
    r.wrap = p.wrap;
    if (s >= FL_DEPTH) begin
      s      = s - FL_DEPTH;
      r.wrap = ~p.wrap;
    end
    r.idx = idx_t'(s);
    return r;
  endfunction

  // Distance a - b; differing wrap bits mean a has lapped the array once more than b.
  function automatic int ptr_dist(ptr_t a, ptr_t b);
    int d;
    d = int'(a.idx) - int'(b.idx);
    if (a.wrap != b.wrap) d = d + FL_DEPTH;
    return d;
  endfunction

  tag_t r_entry [FL_DEPTH];
  ptr_t r_spec_head;
  ptr_t r_arch_head;
  ptr_t r_tail;
  logic r_err;

  logic [ALLOC_WIDTH-1:0][ACNT_W-1:0] w_alloc_pos;
  logic [ACNT_W-1:0]                  w_alloc_n;
  logic [FREE_WIDTH-1:0]              w_free_vld;
  logic [FREE_WIDTH-1:0][FCNT_W-1:0]  w_free_pos;
  logic [FCNT_W-1:0]                  w_free_n;
  logic [FREE_WIDTH-1:0]              w_free_acc;
  idx_t                               w_wr_idx [FREE_WIDTH];

  int   w_fc_int;
  int   w_inflight;
  int   w_room;
  int   w_free_take;
  logic w_grant_ok;
  logic w_commit_over;
  logic w_free_over;
  ptr_t w_arch_nxt;
  ptr_t w_spec_nxt;
  ptr_t w_tail_nxt;

  // Tag-zero releases are dropped before compaction so they never take a slot.
  always_comb begin
    w_free_vld = '0;
    for (int i = 0; i < FREE_WIDTH; i++) begin
      w_free_vld[i] = free_en[i] && (free_tag[i] != '0);
    end
  end

  lane_prefix_count #(.LANES(ALLOC_WIDTH)) u_alloc_pfx (
    .i_vec    (alloc_req),
    .o_prefix (w_alloc_pos),
    .o_total  (w_alloc_n)
  );

  lane_prefix_count #(.LANES(FREE_WIDTH)) u_free_pfx (
    .i_vec    (w_free_vld),
    .o_prefix (w_free_pos),
    .o_total  (w_free_n)
  );

  // Grant decision, lane tags, commit/flush pointer moves and release compaction.
  always_comb begin
    w_fc_int      = ptr_dist(r_tail, r_spec_head);
    w_grant_ok    = !rst && !flush && (int'(w_alloc_n) <= w_fc_int);
    alloc_grant   = w_grant_ok ? alloc_req : '0;
    alloc_tag     = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      alloc_tag[i] = r_entry[idx_add(r_spec_head.idx, int'(w_alloc_pos[i]))];
    end

    // Retiring more allocations than are in flight is a protocol error; clamp.
    w_inflight    = ptr_dist(r_spec_head, r_arch_head);
    w_commit_over = int'(commit_alloc_cnt) > w_inflight;
    w_arch_nxt    = w_commit_over ? r_spec_head
                                  : ptr_add(r_arch_head, int'(commit_alloc_cnt));

    // Room is measured against the post-commit arch_head so an instruction
    // retiring this cycle can hand back its stale tag in the same cycle.
    w_room      = FL_DEPTH - ptr_dist(r_tail, w_arch_nxt);
    w_free_over = int'(w_free_n) > w_room;
    w_free_take = w_free_over ? w_room : int'(w_free_n);
    w_free_acc  = '0;
    for (int i = 0; i < FREE_WIDTH; i++) begin
      w_free_acc[i] = w_free_vld[i] && (int'(w_free_pos[i]) < w_room);
      w_wr_idx[i]   = idx_add(r_tail.idx, int'(w_free_pos[i]));
    end
    w_tail_nxt = ptr_add(r_tail, w_free_take);

    if (flush) begin
      w_spec_nxt = w_arch_nxt;
    end else if (w_grant_ok) begin
      w_spec_nxt = ptr_add(r_spec_head, int'(w_alloc_n));
    end else begin
      w_spec_nxt = r_spec_head;
    end
  end

  assign free_count = CNT_W'(w_fc_int);
  assign empty      = (w_fc_int == 0);
  assign err        = r_err;

  // Pointer and sticky error state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_spec_head <= '{wrap: 1'b0, idx: '0};
      r_arch_head <= '{wrap: 1'b0, idx: '0};
      r_tail      <= '{wrap: 1'b1, idx: '0};
      r_err       <= 1'b0;
    end else begin
      r_spec_head <= w_spec_nxt;
      r_arch_head <= w_arch_nxt;
      r_tail      <= w_tail_nxt;
      if (w_commit_over || w_free_over) r_err <= 1'b1;
    end
  end

  // Tag storage: reset to the tags not held by the initial architectural map.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        r_entry[i] <= tag_t'(NUM_ARCH_REGS + i);
      end
    end else begin
      for (int i = 0; i < FREE_WIDTH; i++) begin
        if (w_free_acc[i]) r_entry[w_wr_idx[i]] <= free_tag[i];
      end
    end
  end

endmodule

// File: tb/tb_phys_free_list.sv
// Randomized and directed bench for phys_free_list against an integer-pointer free-list model.
// Latency: checks combinational outputs each cycle on the falling edge, before the state update.
// Backpressure: model predicts grant refusal and dropped releases; outputs compared every cycle.
module tb_phys_free_list;

  localparam int D  = 32;
  localparam int AW = 4;
  localparam int FW = 4;
  localparam int PW = 6;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [AW-1:0]        alloc_req;
  logic [AW-1:0]        alloc_grant;
  logic [AW-1:0][PW-1:0] alloc_tag;
  logic [FW-1:0]        free_en;
  logic [FW-1:0][PW-1:0] free_tag;
  logic [2:0]           commit_alloc_cnt;
  logic                 flush;
  logic [5:0]           free_count;
  logic                 empty;
  logic                 err;

  always #5 clk = ~clk;

  phys_free_list dut (
    .clk              (clk),
    .rst              (rst),
    .alloc_req        (alloc_req),
    .alloc_grant      (alloc_grant),
    .alloc_tag        (alloc_tag),
    .free_en          (free_en),
    .free_tag         (free_tag),
    .commit_alloc_cnt (commit_alloc_cnt),
    .flush            (flush),
    .free_count       (free_count),
    .empty            (empty),
    .err              (err)
  );

  // Reference model: monotonically increasing integer pointers, array indexed modulo D.
  int m_mem [D];
  int m_spec, m_arch, m_tail;
  bit m_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0]         obs_grant;
  logic [AW-1:0][PW-1:0] obs_tag;
  int                    obs_fc;
  logic                  obs_err;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_mem[i] = 32 + i;
    m_spec = 0;
    m_arch = 0;
    m_tail = D;
    m_err  = 1'b0;
  endtask

  // One clock cycle: drive, check outputs against the model, advance the model.
  task automatic step(input logic [AW-1:0] areq, input logic [FW-1:0] fen,
                      input logic [FW-1:0][PW-1:0] ftag, input int cmt, input logic fl);
    int  n, fc, k, room;
    bit  g;
    alloc_req        = areq;
    free_en          = fen;
    free_tag         = ftag;
    commit_alloc_cnt = 3'(cmt);
    flush            = fl;
    @(negedge clk);
    n  = $countones(areq);
    fc = m_tail - m_spec;
    g  = !fl && (n <= fc);
    chk_eq("grant", 32'(alloc_grant), g ? 32'(areq) : 32'd0);
    chk_eq("free_count", 32'(free_count), 32'(fc));
    chk_eq("empty", 32'(empty), 32'(fc == 0));
    chk_eq("err", 32'(err), 32'(m_err));
    if (g) begin
      k = 0;
      for (int i = 0; i < AW; i++) begin
        if (areq[i]) begin
          chk_eq($sformatf("tag%0d", i), 32'(alloc_tag[i]), 32'(m_mem[(m_spec + k) % D]));
          k++;
        end
      end
    end
    obs_grant = alloc_grant;
    obs_tag   = alloc_tag;
    obs_fc    = int'(free_count);
    obs_err   = err;

    if (cmt > m_spec - m_arch) begin
      m_arch = m_spec;
      m_err  = 1'b1;
    end else begin
      m_arch = m_arch + cmt;
    end
    room = D - (m_tail - m_arch);
    for (int i = 0; i < FW; i++) begin
      if (fen[i] && ftag[i] != '0) begin
        if (room > 0) begin
          m_mem[m_tail % D] = int'(ftag[i]);
          m_tail++;
          room--;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    if (fl) m_spec = m_arch;
    else if (g) m_spec = m_spec + n;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step('0, '0, '0, 0, 1'b0);
  endtask

  // Reset with arbitrary traffic on the inputs; all of it must be discarded.
  task automatic do_reset();
    rst              = 1'b1;
    alloc_req        = 4'($urandom);
    free_en          = 4'($urandom);
    free_tag         = 24'($urandom);
    commit_alloc_cnt = 3'($urandom_range(0, 4));
    flush            = 1'($urandom);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic rand_cycle();
    logic [AW-1:0]         areq;
    logic [FW-1:0]         fen;
    logic [FW-1:0][PW-1:0] ft;
    int inflight, c, room, nf, cnt;
    areq     = 4'($urandom);
    inflight = m_spec - m_arch;
    if ($urandom_range(0, 19) == 0) c = $urandom_range(0, 4);
    else c = $urandom_range(0, imin(4, inflight));
    room = D - (m_tail - (m_arch + imin(c, inflight)));
    if ($urandom_range(0, 19) == 0) nf = 4;
    else nf = $urandom_range(0, imin(4, room));
    fen = 4'($urandom);
    cnt = 0;
    for (int i = 0; i < FW; i++) begin
      if (fen[i]) begin
        if (cnt >= nf) fen[i] = 1'b0;
        else cnt++;
      end
      ft[i] = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
    end
    step(areq, fen, ft, c, $urandom_range(0, 15) == 0);
  endtask

  initial begin
    logic [FW-1:0][PW-1:0] ft;
    rst = 1'b1;
    alloc_req = '0; free_en = '0; free_tag = '0; commit_alloc_cnt = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Post-reset state.
    idle();
    chk_eq("rst_fc", 32'(obs_fc), 32'd32);
    chk_eq("rst_grant", 32'(obs_grant), 32'd0);
    chk_eq("rst_err", 32'(obs_err), 32'd0);

    // Full-width allocation from reset.
    do_reset();
    step(4'b1111, '0, '0, 0, 1'b0);
    chk_eq("a4_grant", 32'(obs_grant), 32'hF);
    for (int i = 0; i < 4; i++) chk_eq($sformatf("a4_tag%0d", i), 32'(obs_tag[i]), 32'(32 + i));
    idle();
    chk_eq("a4_fc", 32'(obs_fc), 32'd28);

    // Sparse mask compacts tags onto requesting lanes.
    do_reset();
    step(4'b1010, '0, '0, 0, 1'b0);
    chk_eq("sp_grant", 32'(obs_grant), 32'hA);
    chk_eq("sp_tag1", 32'(obs_tag[1]), 32'd32);
    chk_eq("sp_tag3", 32'(obs_tag[3]), 32'd33);
    idle();
    chk_eq("sp_fc", 32'(obs_fc), 32'd30);

    // Drain to 3: a 4-wide request is refused outright, a 3-wide one fits.
    do_reset();
    repeat (7) step(4'b1111, '0, '0, 0, 1'b0);
    step(4'b0001, '0, '0, 0, 1'b0);
    step(4'b1111, '0, '0, 0, 1'b0);
    chk_eq("dr_refuse", 32'(obs_grant), 32'd0);
    chk_eq("dr_fc3", 32'(obs_fc), 32'd3);
    step(4'b0111, '0, '0, 0, 1'b0);
    chk_eq("dr_grant", 32'(obs_grant), 32'h7);
    idle();
    chk_eq("dr_empty_fc", 32'(obs_fc), 32'd0);

    // Empty list: same-cycle release must not bypass into allocation.
    step('0, '0, '0, 2, 1'b0);
    ft = '0; ft[0] = 6'd40; ft[1] = 6'd41;
    step(4'b0001, 4'b0011, ft, 0, 1'b0);
    chk_eq("nb_nogrant", 32'(obs_grant), 32'd0);
    step(4'b0001, '0, '0, 0, 1'b0);
    chk_eq("nb_grant", 32'(obs_grant), 32'h1);
    chk_eq("nb_tag", 32'(obs_tag[0]), 32'd40);

    // Flush rewinds the speculative head to the committed point.
    do_reset();
    step(4'b1111, '0, '0, 0, 1'b0);
    step(4'b1111, '0, '0, 0, 1'b0);
    step('0, '0, '0, 2, 1'b0);
    step(4'b0011, '0, '0, 0, 1'b1);
    chk_eq("fl_nogrant", 32'(obs_grant), 32'd0);
    idle();
    chk_eq("fl_fc", 32'(obs_fc), 32'd30);
    step(4'b0001, '0, '0, 0, 1'b0);
    chk_eq("fl_tag", 32'(obs_tag[0]), 32'd34);

    // Release into a full list is dropped and flagged stickily.
    do_reset();
    ft = '0; ft[0] = 6'd50;
    step('0, 4'b0001, ft, 0, 1'b0);
    idle();
    chk_eq("ov_err", 32'(obs_err), 32'd1);
    chk_eq("ov_fc", 32'(obs_fc), 32'd32);
    repeat (3) idle();
    chk_eq("ov_sticky", 32'(obs_err), 32'd1);

    // Tag zero is silently ignored.
    do_reset();
    step('0, 4'b0001, '0, 0, 1'b0);
    idle();
    chk_eq("z_err", 32'(obs_err), 32'd0);
    chk_eq("z_fc", 32'(obs_fc), 32'd32);

    // Random traffic with occasional mid-operation resets.
    for (int seg = 0; seg < 3; seg++) begin
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
        if ($urandom_range(0, 149) == 0) do_reset();
        else rand_cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phys_free_list.md
PHYS_FREE_LIST -- requirements
Module: phys_free_list

Interface
REQ-001 Parameter NUM_PHYS_REGS, default 64, total physical registers.
REQ-002 Parameter NUM_ARCH_REGS, default 32, architectural registers; FL_DEPTH = NUM_PHYS_REGS-NUM_ARCH_REGS.
REQ-003 Parameter ALLOC_WIDTH, default 4, rename lanes per cycle.
REQ-004 Parameter FREE_WIDTH, default 4, commit-release lanes per cycle.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 alloc_req  input  ALLOC_WIDTH  per-lane request for a new destination tag (any mask).
REQ-008 alloc_grant  output  ALLOC_WIDTH  per-lane grant; equals alloc_req or all-zero.
REQ-009 alloc_tag  output  ALLOC_WIDTH x PREG_BITS  tag per lane; valid only where granted; drives regfile clear_ready_addr.
REQ-010 free_en  input  FREE_WIDTH  per-lane release of a committed stale tag.
REQ-011 free_tag  input  FREE_WIDTH x PREG_BITS  tag being released.
REQ-012 commit_alloc_cnt  input  $clog2(ALLOC_WIDTH+1)  number of allocating instructions retired this cycle.
REQ-013 flush  input  1  misprediction/exception recovery.
REQ-014 free_count  output  $clog2(FL_DEPTH+1)  entries currently available for allocation.
REQ-015 empty  output  1  free_count == 0.
REQ-016 err  output  1  sticky protocol-error flag.

Function
REQ-017 Storage: circular array of FL_DEPTH tags; pointers spec_head, arch_head, tail each carry one wrap bit.
REQ-018 free_count = tail - spec_head (modulo 2*FL_DEPTH), registered-state based, combinational output.
REQ-019 Allocation all-or-nothing: grant iff popcount(alloc_req) <= free_count and flush == 0; otherwise alloc_grant = 0.
REQ-020 Lane i tag = entry[spec_head + popcount(alloc_req[i-1:0])]; zero-latency (same-cycle combinational).
REQ-021 On grant, spec_head advances by popcount(alloc_req) at the clock edge.
REQ-022 Tags freed in cycle N are allocatable no earlier than cycle N+1 (no free-to-alloc bypass).
REQ-023 Release: enabled lanes with free_tag != 0 are written at tail in ascending lane order, compacted; tail advances by their count.
REQ-024 free_en with free_tag == 0 is silently dropped.
REQ-025 Release that would make tail - arch_head exceed FL_DEPTH: excess lanes dropped, err set.
REQ-026 arch_head advances by commit_alloc_cnt each cycle; if commit_alloc_cnt > spec_head - arch_head, arch_head clamps to spec_head and err set.
REQ-027 flush: spec_head <= arch_head after that cycle's commit_alloc_cnt advance; same-cycle releases still accepted; alloc_grant forced 0.
REQ-028 Pointer wrap: index wraps at FL_DEPTH, wrap bit toggles; full/empty distinguished by wrap bit.
REQ-029 err clears only on rst.

Reset
REQ-030 On rst: entry[i] = NUM_ARCH_REGS+i for all i; spec_head = arch_head = 0 (wrap 0); tail = index 0 wrap 1.
REQ-031 Post-reset outputs: free_count = FL_DEPTH, empty = 0, err = 0, alloc_grant = 0 while alloc_req = 0.
REQ-032 rst mid-operation discards all in-flight allocations and releases of that cycle.

Structure
REQ-033 Shared package ooo_pkg holds NUM_PHYS_REGS, NUM_ARCH_REGS, PREG_BITS and typedef preg_t, shared with the physical register file and rename table.
REQ-034 One sub-module, lane_prefix_count, computes per-lane exclusive prefix popcount, instantiated for both alloc and free compaction.

Verification
REQ-035 Reset, alloc_req=4'b1111 -> grant 1111, tags 32,33,34,35; next cycle free_count=28.
REQ-036 alloc_req=4'b1010 from reset -> lane1=32, lane3=33; lanes 0/2 not granted; free_count 30.
REQ-037 Drain to free_count=3, alloc_req=4'b1111 -> grant 0000, count unchanged; alloc_req=4'b0111 -> granted.
REQ-038 Allocate 8, commit_alloc_cnt=2, then flush -> free_count=30 next cycle; next alloc returns 34.
REQ-039 free_count=0, free_en=4'b0011 tags 40,41 same cycle as alloc_req=1 -> no grant; next cycle grant tag 40.
REQ-040 At reset state free_en=1 tag 50 -> dropped, err=1 and stays 1; free_tag 0 alone -> no err, no change.
